pinwheel_regfile_mp: RTL and testbench

Multi-threaded, multi-read-port register file for the pinwheel core; the parametrised successor to the two-port thread regfile. Holds `thread_count` banks of `reg_count` registers and serves `read_ports` synchronous reads per cycle. It adds a hardwired-zero x0, optional write-to-read bypass, and a sequential clear engine. The clear engine zeroes all storage after reset and zeroes a single thread's bank on request.

---
 rtl/pinwheel_regfile_pkg.sv | 17 +
 rtl/block_ram.sv | 22 ++
 rtl/pinwheel_regfile_mp.sv | 162 ++++++++++++++++
 tb/tb_pinwheel_regfile_mp.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinwheel_regfile_pkg.sv
// Shared types and helpers for the pinwheel multi-port thread register file.
package pinwheel_regfile_pkg;

   typedef enum logic [1:0] {
      RF_INIT,
      RF_IDLE,
      RF_CLEAR
   } regfile_state_e;

   // Flat entry index of {thread, reg}; the register index occupies the low reg_bits bits.
   function automatic int unsigned rf_addr(input int unsigned thread,
                                           input int unsigned reg_idx,
                                           input int unsigned reg_bits);
      return (thread << reg_bits) | reg_idx;
   endfunction

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module block_ram #(
   parameter int unsigned addr_bits = 7,
   parameter int unsigned data_bits = 32
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [addr_bits-1:0] waddr,
   input  logic [data_bits-1:0] wdata,
   input  logic [addr_bits-1:0] raddr,
   output logic [data_bits-1:0] rdata
);
   localparam int unsigned depth = 2 ** addr_bits;

   logic [data_bits-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/pinwheel_regfile_mp.sv
// Multi-threaded, multi-read-port register file with hardwired x0 and a sequential clear engine.
// Define PINWHEEL_REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module pinwheel_regfile_mp
   import pinwheel_regfile_pkg::*;
#(
   parameter  int unsigned reg_count    = 32,
   parameter  int unsigned reg_width    = 32,
   parameter  int unsigned thread_count = 4,
   parameter  int unsigned read_ports   = 2,
   localparam int unsigned reg_bits     = $clog2(reg_count),
   localparam int unsigned thread_bits  = (thread_count > 1) ? $clog2(thread_count) : 1,
   localparam int unsigned addr_bits    = $clog2(reg_count * thread_count)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [read_ports*addr_bits-1:0] raddr,
   output logic [read_ports*reg_width-1:0] rdata,
   input  logic [addr_bits-1:0]            waddr,
   input  logic [reg_width-1:0]            wdata,
   input  logic                            wren,
   output logic                            wready,
   input  logic                            clear_req,
   input  logic [thread_bits-1:0]          clear_thread,
   output logic                            busy,
   output logic                            clear_done
);
   localparam int unsigned          entries    = reg_count * thread_count;
   localparam logic [addr_bits-1:0] last_entry = addr_bits'(entries - 1);
   localparam logic [addr_bits-1:0] last_reg   = addr_bits'(reg_count - 1);

   regfile_state_e         state, state_n;
   logic [addr_bits-1:0]   cnt, cnt_n;
   logic [thread_bits-1:0] clr_thread, clr_thread_n;
   logic                   done_n;

   logic                   ext_we;
   logic                   ram_we;
   logic [addr_bits-1:0]   eng_addr;
   logic [addr_bits-1:0]   ram_waddr;
   logic [reg_width-1:0]   ram_wdata;

   function automatic logic [thread_bits-1:0] thread_of(input logic [addr_bits-1:0] a);
      return thread_bits'(a >> reg_bits);
   endfunction

   // Engine state register; busy/wready/clear_done are registered from next-state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RF_INIT;
         cnt        <= '0;
         clr_thread <= '0;
         busy       <= 1'b1;
         wready     <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         clr_thread <= clr_thread_n;
         busy       <= (state_n != RF_IDLE);
         wready     <= (state_n == RF_IDLE);
         clear_done <= done_n;
      end
   end

   // Walk every entry after reset; walk one thread's bank on request.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      clr_thread_n = clr_thread;
      done_n       = 1'b0;
      case (state)
         RF_INIT: begin
            cnt_n = cnt + addr_bits'(1);
            if (cnt == last_entry) begin
               state_n = RF_IDLE;
               cnt_n   = '0;
            end
         end
         RF_IDLE: begin
            if (clear_req) begin
               state_n      = RF_CLEAR;
               clr_thread_n = clear_thread;
               cnt_n        = '0;
            end
         end
         RF_CLEAR: begin
            cnt_n = cnt + addr_bits'(1);
            if (cnt == last_reg) begin
               state_n = RF_IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = RF_INIT;
            cnt_n   = '0;
         end
      endcase
   end

   assign ext_we = wren && wready && (waddr[reg_bits-1:0] != '0);

   // Shared RAM write port: engine zeroes while busy, otherwise the external write.
   always_comb begin
      eng_addr = cnt;
      if (state == RF_CLEAR)
         eng_addr = addr_bits'(rf_addr(32'(clr_thread), 32'(cnt[reg_bits-1:0]), reg_bits));
      ram_we    = busy || ext_we;
      ram_waddr = busy ? eng_addr : waddr;
      ram_wdata = busy ? '0 : wdata;
   end

`ifdef PINWHEEL_REGFILE_BYPASS_EN
   logic [reg_width-1:0] wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdata_q <= '0;
      else     wdata_q <= wdata;
   end
`endif

   for (genvar k = 0; k < read_ports; k++) begin : g_port
      logic [addr_bits-1:0] ra;
      logic [reg_width-1:0] ram_q;
      logic                 zero_q;

      assign ra = raddr[k*addr_bits +: addr_bits];

      block_ram #(
         .addr_bits (addr_bits),
         .data_bits (reg_width)
      ) u_ram (
         .clk   (clk),
         .we    (ram_we),
         .waddr (ram_waddr),
         .wdata (ram_wdata),
         .raddr (ra),
         .rdata (ram_q)
      );

      // x0, storage being initialised, or a bank being cleared all read as zero.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) zero_q <= 1'b1;
         else     zero_q <= (ra[reg_bits-1:0] == '0) || (state == RF_INIT) ||
                            ((state == RF_CLEAR) && (thread_of(ra) == clr_thread));
      end

`ifdef PINWHEEL_REGFILE_BYPASS_EN
      logic byp_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) byp_q <= 1'b0;
         else     byp_q <= ext_we && (waddr == ra);
      end

      assign rdata[k*reg_width +: reg_width] = zero_q ? '0 : (byp_q ? wdata_q : ram_q);
`else
      assign rdata[k*reg_width +: reg_width] = zero_q ? '0 : ram_q;
`endif
   end

endmodule

// File: tb/tb_pinwheel_regfile_mp.sv
// Self-checking bench for pinwheel_regfile_mp: table vectors, directed clear/reset sequences, random traffic.
module tb_pinwheel_regfile_mp;
   localparam int unsigned RC    = 32;
   localparam int unsigned RW    = 32;
   localparam int unsigned TC    = 4;
   localparam int unsigned RP    = 2;
   localparam int unsigned AB    = 7;
   localparam int unsigned TBITS = 2;
   localparam int unsigned NE    = RC * TC;
`ifdef PINWHEEL_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [RP*AB-1:0] raddr;
   logic [RP*RW-1:0] rdata;
   logic [AB-1:0]    waddr;
   logic [RW-1:0]    wdata;
   logic             wren;
   logic             wready;
   logic             clear_req;
   logic [TBITS-1:0] clear_thread;
   logic             busy;
   logic             clear_done;
   logic [AB-1:0]    ra [RP];

   assign raddr = {ra[1], ra[0]};

   pinwheel_regfile_mp dut (
      .clk          (clk),
      .rst          (rst),
      .raddr        (raddr),
      .rdata        (rdata),
      .waddr        (waddr),
      .wdata        (wdata),
      .wren         (wren),
      .wready       (wready),
      .clear_req    (clear_req),
      .clear_thread (clear_thread),
      .busy         (busy),
      .clear_done   (clear_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model: architectural contents plus remaining engine cycles.
   logic [RW-1:0] mem [NE];
   int init_left;
   int clear_left;
   int clear_thr;

   typedef struct {
      logic          wren;
      logic [AB-1:0] waddr;
      logic [RW-1:0] wdata;
      logic [AB-1:0] ra0;
      logic [AB-1:0] ra1;
      logic [RW-1:0] e0;
      logic [RW-1:0] e1;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] pat(input int t, input int r);
      return 32'(32'h1000_0000 * (t + 1) + r);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NE; i++) mem[i] = '0;
      init_left  = NE;
      clear_left = 0;
      clear_thr  = 0;
   endtask

   // One clock edge with the currently driven inputs, checked against the model.
   task automatic tick();
      logic [RW-1:0] er [RP];
      logic acc;
      logic ed;
      logic eb;
      acc = (init_left == 0) && (clear_left == 0) && wren && ((int'(waddr) % RC) != 0);
      for (int k = 0; k < RP; k++) begin
         int a = int'(ra[k]);
         if ((a % RC) == 0 || init_left > 0 || (clear_left > 0 && (a / RC) == clear_thr))
            er[k] = '0;
         else if (BYP && acc && int'(waddr) == a)
            er[k] = wdata;
         else
            er[k] = mem[a];
      end
      if (acc) mem[waddr] = wdata;
      ed = 1'b0;
      if (init_left > 0) begin
         init_left--;
      end else if (clear_left > 0) begin
         clear_left--;
         ed = (clear_left == 0);
      end else if (clear_req) begin
         clear_thr  = int'(clear_thread);
         clear_left = RC;
         for (int r = 0; r < RC; r++) mem[clear_thr*RC + r] = '0;
      end
      eb = (init_left > 0) || (clear_left > 0);
      @(posedge clk);
      #1;
      check("rdata0", rdata[RW-1:0], er[0]);
      check("rdata1", rdata[2*RW-1:RW], er[1]);
      check("busy", 32'(busy), 32'(eb));
      check("wready", 32'(wready), 32'(!eb));
      check("clear_done", 32'(clear_done), 32'(ed));
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      wren      = 1'b0;
      clear_req = 1'b0;
      model_reset();
      #1;
      check("rst_rdata0", rdata[RW-1:0], '0);
      check("rst_rdata1", rdata[2*RW-1:RW], '0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int cyc;
      int dones;
      n_vec        = 0;
      n_err        = 0;
      rst          = 1'b1;
      wren         = 1'b0;
      waddr        = '0;
      wdata        = '0;
      clear_req    = 1'b0;
      clear_thread = '0;
      ra[0]        = '0;
      ra[1]        = '0;

      tbl[0] = '{1'b1, 7'h23, 32'hDEADBEEF, 7'h45, 7'h23, 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
      tbl[1] = '{1'b0, 7'h00, 32'h0,        7'h23, 7'h23, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 7'h20, 32'h1234,     7'h20, 7'h20, 32'h0, 32'h0};
      tbl[3] = '{1'b0, 7'h00, 32'h0,        7'h20, 7'h00, 32'h0, 32'h0};
      tbl[4] = '{1'b1, 7'h07, 32'hA5A5A5A5, 7'h07, 7'h23, BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF};
      tbl[5] = '{1'b0, 7'h00, 32'h0,        7'h07, 7'h45, 32'hA5A5A5A5, 32'h0};
      tbl[6] = '{1'b1, 7'h7F, 32'h0BADF00D, 7'h07, 7'h7F, 32'hA5A5A5A5, BYP ? 32'h0BADF00D : 32'h0};
      tbl[7] = '{1'b0, 7'h00, 32'h0,        7'h7F, 7'h60, 32'h0BADF00D, 32'h0};

      do_reset();

      // Initialisation walk length.
      cyc = 0;
      while (busy && cyc < NE + 20) begin
         tick();
         cyc++;
      end
      check("init_len", 32'(cyc), 32'(NE));

      for (int i = 0; i < 8; i++) begin
         wren  = tbl[i].wren;
         waddr = tbl[i].waddr;
         wdata = tbl[i].wdata;
         ra[0] = tbl[i].ra0;
         ra[1] = tbl[i].ra1;
         tick();
         check("tbl_p0", rdata[RW-1:0], tbl[i].e0);
         check("tbl_p1", rdata[2*RW-1:RW], tbl[i].e1);
      end
      wren = 1'b0;

      // Random traffic with occasional clears.
      for (int i = 0; i < 2000; i++) begin
         wren         = ($urandom_range(0, 3) != 0);
         waddr        = AB'($urandom_range(0, NE - 1));
         wdata        = $urandom;
         ra[0]        = AB'($urandom_range(0, NE - 1));
         ra[1]        = ($urandom_range(0, 3) == 0) ? waddr : AB'($urandom_range(0, NE - 1));
         clear_req    = ($urandom_range(0, 59) == 0);
         clear_thread = TBITS'($urandom_range(0, TC - 1));
         tick();
      end
      wren      = 1'b0;
      clear_req = 1'b0;
      cyc = 0;
      while (busy && cyc < RC + 20) begin
         tick();
         cyc++;
      end

      // Fill every thread with a known pattern.
      for (int t = 0; t < TC; t++) begin
         for (int r = 1; r < RC; r++) begin
            wren  = 1'b1;
            waddr = AB'(t * RC + r);
            wdata = pat(t, r);
            tick();
         end
      end
      wren = 1'b0;

      // Clear thread 2, with a dropped write and an ignored second request.
      clear_req    = 1'b1;
      clear_thread = 2'd2;
      tick();
      clear_req = 1'b0;
      cyc   = 0;
      dones = 0;
      while (busy && cyc < RC + 20) begin
         wren         = (cyc == 3);
         waddr        = AB'(5);
         wdata        = 32'hFFFF0000;
         clear_req    = (cyc == 5);
         clear_thread = 2'd1;
         tick();
         cyc++;
         if (clear_done) dones++;
      end
      wren      = 1'b0;
      clear_req = 1'b0;
      check("clear_len", 32'(cyc), 32'(RC));
      check("clear_done_cnt", 32'(dones), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (clear_done) dones++;
      end
      check("clear_done_extra", 32'(dones), 32'd1);

      for (int r = 0; r < RC; r++) begin
         int t;
         t     = (r % 3 == 2) ? 3 : (r % 3);
         ra[0] = AB'(2 * RC + r);
         ra[1] = AB'(t * RC + r);
         tick();
         check("cleared_t2", rdata[RW-1:0], '0);
         check("kept_data", rdata[2*RW-1:RW], (r == 0) ? 32'h0 : pat(t, r));
      end
      ra[0] = AB'(5);
      tick();
      check("dropped_write", rdata[RW-1:0], pat(0, 5));

      // Reset in the middle of a clear.
      clear_req    = 1'b1;
      clear_thread = 2'd1;
      tick();
      clear_req = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (clear_done) dones++;
      end
      do_reset();
      cyc = 0;
      while (busy && cyc < NE + 20) begin
         tick();
         cyc++;
         if (clear_done) dones++;
      end
      check("init_rerun", 32'(cyc), 32'(NE));
      check("abort_no_done", 32'(dones), 32'd0);
      for (int i = 0; i < 16; i++) begin
         ra[0] = AB'($urandom_range(0, NE - 1));
         ra[1] = AB'($urandom_range(0, NE - 1));
         tick();
         check("post_rst_p0", rdata[RW-1:0], '0);
         check("post_rst_p1", rdata[2*RW-1:RW], '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
